spu_ls_pipe: RTL and testbench

Parametrised single-port local-store pipe for the SPU odd pipeline. It executes quadword loads and stores in x-, d- and a-form addressing, computes byte addresses with local-store wrap and alignment, and returns load results through a configurable-depth writeback delay line. A second DMA channel shares the memory port at lower priority through a valid/ready handshake.

---
 rtl/spu_ls_pipe.sv | 96 +++++++++
 tb/tb_spu_ls_pipe.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/spu_ls_pipe.sv
// spu_ls_pipe: SPU odd-pipe local-store load/store pipe with a lower-priority DMA port
module spu_ls_pipe #(
    parameter int DATA_W   = 128,
    parameter int DEPTH    = 2048,
    parameter int LATENCY  = 6,
    parameter int RT_W     = 7,
    parameter int QW_IDX_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ls_valid,
    input  logic                ls_store,
    input  logic [1:0]          ls_mode,
    input  logic [31:0]         ls_ra,
    input  logic [31:0]         ls_rb,
    input  logic [15:0]         ls_imm,
    input  logic [RT_W-1:0]     ls_rt_addr,
    input  logic [DATA_W-1:0]   ls_rt_data,
    input  logic                flush,
    output logic                wb_valid,
    output logic [DATA_W-1:0]   wb_data,
    output logic [RT_W-1:0]     wb_rt_addr,
    input  logic                dma_valid,
    input  logic                dma_write,
    input  logic [QW_IDX_W-1:0] dma_qw_addr,
    input  logic [DATA_W-1:0]   dma_wdata,
    output logic                dma_ready,
    output logic                dma_rvalid,
    output logic [DATA_W-1:0]   dma_rdata
);
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [31:0]         ea;
    logic [QW_IDX_W-1:0] idx;
    logic                issue, load, dma_rd;
    logic [LATENCY-1:0]  st_v;
    logic [DATA_W-1:0]   st_d [LATENCY];
    logic [RT_W-1:0]     st_a [LATENCY];

    // Any unflushed ls_valid owns the port, even an illegal mode that is then dropped.
    assign issue     = ls_valid & ~flush & (ls_mode != 2'd3);
    assign load      = issue & ~ls_store;
    assign dma_ready = dma_valid & ~(ls_valid & ~flush) & ~reset;
    assign dma_rd    = dma_ready & ~dma_write;

    // Effective byte address: x-form, d-form (imm10 qword offset), a-form (imm16 word address).
    always_comb
        ea = ls_mode == 2'd0 ? ls_ra + ls_rb :
             ls_mode == 2'd1 ? ls_ra + {{18{ls_imm[9]}}, ls_imm[9:0], 4'b0} :
                               {{14{ls_imm[15]}}, ls_imm, 2'b0};

    // Dropping the low nibble and the bits above the store size wraps the address.
    assign idx = QW_IDX_W'(ea >> 4);

    // Memory writes; stores and DMA writes never collide because the LS pipe blocks DMA.
    always_ff @(posedge clk) begin
        if (!reset && issue && ls_store)
            mem[idx] <= ls_rt_data;
        else if (dma_ready && dma_write)
            mem[dma_qw_addr] <= dma_wdata;
    end

    // Writeback delay line: stage 0 captures load data, then shifts every cycle without stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_v <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                st_d[i] <= '0;
                st_a[i] <= '0;
            end
        end else begin
            st_v    <= {st_v[LATENCY-2:0], load};
            st_d[0] <= load ? mem[idx] : '0;
            st_a[0] <= load ? ls_rt_addr : '0;
            for (int i = 1; i < LATENCY; i++) begin
                st_d[i] <= st_d[i-1];
                st_a[i] <= st_a[i-1];
            end
        end
    end

    assign wb_valid   = st_v[LATENCY-1];
    assign wb_data    = st_d[LATENCY-1];
    assign wb_rt_addr = st_a[LATENCY-1];

    // DMA read return: one-cycle valid pulse, data held between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            dma_rvalid <= 1'b0;
            dma_rdata  <= '0;
        end else begin
            dma_rvalid <= dma_rd;
            if (dma_rd)
                dma_rdata <= mem[dma_qw_addr];
        end
    end
endmodule

// File: tb/tb_spu_ls_pipe.sv
// tb_spu_ls_pipe: scoreboard bench for the local-store pipe and its DMA port
module tb_spu_ls_pipe;
    localparam int DW  = 128;
    localparam int DEP = 2048;
    localparam int LAT = 6;
    localparam int RW  = 7;
    localparam int IW  = 11;

    logic          clk = 0, reset = 1;
    logic          ls_valid = 0, ls_store = 0, flush = 0;
    logic [1:0]    ls_mode = 0;
    logic [31:0]   ls_ra = 0, ls_rb = 0;
    logic [15:0]   ls_imm = 0;
    logic [RW-1:0] ls_rt_addr = 0;
    logic [DW-1:0] ls_rt_data = 0;
    logic          wb_valid;
    logic [DW-1:0] wb_data;
    logic [RW-1:0] wb_rt_addr;
    logic          dma_valid = 0, dma_write = 0;
    logic [IW-1:0] dma_qw_addr = 0;
    logic [DW-1:0] dma_wdata = 0;
    logic          dma_ready, dma_rvalid;
    logic [DW-1:0] dma_rdata;

    spu_ls_pipe dut (
        .clk(clk), .reset(reset), .ls_valid(ls_valid), .ls_store(ls_store), .ls_mode(ls_mode),
        .ls_ra(ls_ra), .ls_rb(ls_rb), .ls_imm(ls_imm), .ls_rt_addr(ls_rt_addr),
        .ls_rt_data(ls_rt_data), .flush(flush), .wb_valid(wb_valid), .wb_data(wb_data),
        .wb_rt_addr(wb_rt_addr), .dma_valid(dma_valid), .dma_write(dma_write),
        .dma_qw_addr(dma_qw_addr), .dma_wdata(dma_wdata), .dma_ready(dma_ready),
        .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata)
    );

    typedef struct {
        int            due;
        logic [RW-1:0] rt;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          wbq[$], dq[$];
    logic [DW-1:0] model [DEP];
    logic [DW-1:0] last_rd = 0;
    int            cyc = 0, n_chk = 0, n_fail = 0;
    bit            started = 0;

    localparam logic [DW-1:0] PAT = 128'h00112233445566778899AABBCCDDEEFF;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(string tag, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int ea_idx(logic [1:0] mode, logic [31:0] ra, logic [31:0] rb, logic [15:0] imm);
        int s;
        logic [31:0] ea;
        if (mode == 0) ea = ra + rb;
        else if (mode == 1) begin s = $signed(imm[9:0]); ea = ra + s * 16; end
        else begin s = $signed(imm); ea = s * 4; end
        return int'((ea >> 4) % DEP);
    endfunction

    // One cycle of stimulus; the scoreboard is filled as the stimulus is driven.
    task automatic step(logic lv, logic st, logic [1:0] md, logic [31:0] ra, logic [31:0] rb,
                        logic [15:0] imm, logic [RW-1:0] rt, logic [DW-1:0] d, logic fl,
                        logic dv, logic dw, logic [IW-1:0] da, logic [DW-1:0] dd);
        int   i;
        logic rdy;
        exp_t e;
        ls_valid = lv; ls_store = st; ls_mode = md; ls_ra = ra; ls_rb = rb; ls_imm = imm;
        ls_rt_addr = rt; ls_rt_data = d; flush = fl;
        dma_valid = dv; dma_write = dw; dma_qw_addr = da; dma_wdata = dd;
        #1;
        rdy = dv & ~(lv & ~fl);
        if (dv) chk("dma_ready", dma_ready, rdy);
        if (lv && !fl && md != 3) begin
            i = ea_idx(md, ra, rb, imm);
            if (st) model[i] = d;
            else begin e.due = cyc + LAT; e.rt = rt; e.data = model[i]; wbq.push_back(e); end
        end
        if (rdy) begin
            if (dw) model[da] = dd;
            else begin e.due = cyc + 1; e.rt = 0; e.data = model[da]; dq.push_back(e); end
        end
        @(posedge clk); #1;
        ls_valid = 0; flush = 0; dma_valid = 0;
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic ld(logic [1:0] md, logic [31:0] ra, logic [31:0] rb, logic [15:0] imm, logic [RW-1:0] rt);
        step(1, 0, md, ra, rb, imm, rt, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic sto(logic [1:0] md, logic [31:0] ra, logic [31:0] rb, logic [15:0] imm, logic [DW-1:0] d);
        step(1, 1, md, ra, rb, imm, 0, d, 0, 0, 0, 0, 0);
    endtask

    task automatic dwr(logic [IW-1:0] a, logic [DW-1:0] d);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, a, d);
    endtask

    task automatic drd(logic [IW-1:0] a);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, a, 0);
    endtask

    // Output monitor: compares writebacks and DMA returns against the scoreboard every cycle.
    always @(negedge clk) begin
        if (started) begin
            if (wbq.size() > 0 && wbq[0].due == cyc) begin
                chk("wb_valid", wb_valid, 1);
                chk("wb_rt_addr", wb_rt_addr, wbq[0].rt);
                chk("wb_data", wb_data, wbq[0].data);
                void'(wbq.pop_front());
            end else chk("wb_idle", wb_valid, 0);
            if (dq.size() > 0 && dq[0].due == cyc) begin
                chk("dma_rvalid", dma_rvalid, 1);
                chk("dma_rdata", dma_rdata, dq[0].data);
                last_rd = dq[0].data;
                void'(dq.pop_front());
            end else begin
                chk("dma_idle", dma_rvalid, 0);
                if (!reset) chk("dma_hold", dma_rdata, last_rd);
            end
        end
    end

    initial begin
        for (int i = 0; i < DEP; i++) model[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        @(negedge clk);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_rt", wb_rt_addr, 0);
        chk("rst_rvalid", dma_rvalid, 0);
        chk("rst_rdata", dma_rdata, 0);
        @(posedge clk); #1;
        started = 1;
        for (int i = 0; i < 32; i++) dwr(i[IW-1:0], {4{$urandom}});
        dwr(5, PAT);
        dwr(2047, {4{32'hDEAD_BEEF}});
        ld(2, 0, 0, 16'h0014, 9);
        sto(1, 32'h100, 0, 16'h03FF, {4{32'hCAFE_F00D}});
        ld(0, 32'hF8, 32'h4, 0, 3);
        ld(0, 32'h0007_FFF0, 32'h20, 0, 4);
        ld(2, 0, 0, 16'hFFFC, 5);
        ld(1, 32'h40, 0, 16'h0001, 6);
        step(1, 0, 3, 0, 0, 16'h0014, 7, 0, 0, 1, 0, 5, 0);
        step(1, 1, 3, 0, 0, 16'h0008, 0, {4{32'h1111_1111}}, 0, 0, 0, 0, 0);
        ld(2, 0, 0, 16'h0008, 8);
        idle(8);
        step(1, 0, 2, 0, 0, 16'h0014, 10, 0, 1, 1, 0, 5, 0);
        idle(8);
        for (int k = 0; k < 3; k++) step(1, 0, 0, 32'h50, k * 16, 0, 11 + k, 0, 0, 1, 0, 15, 0);
        drd(15);
        sto(0, 32'h10, 32'h20, 0, {4{32'h5A5A_A5A5}});
        ld(0, 32'h30, 0, 0, 20);
        dwr(3, PAT ^ {4{32'hFFFF_0000}});
        drd(3);
        idle(8);
        ld(2, 0, 0, 16'h0014, 21);
        idle(2);
        reset = 1;
        wbq.delete();
        dq.delete();
        last_rd = 0;
        idle(2);
        reset = 0;
        idle(8);
        drd(5);
        ld(1, 32'h100, 0, 16'h03FF, 22);
        idle(8);
        chk("wbq_drained", wbq.size(), 0);
        chk("dq_drained", dq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end
endmodule
